spi_sram_arbiter: RTL and testbench

//  Shares one spi_sram_master (single SPI SRAM, 24-bit address) among NREQ byte-burst requesters
//  (e.g. CPU cache line fill/writeback, debug/DMA loader). Round-robin grant, burst-locked: a granted

---
 rtl/spi_sram_pkg.sv | 18 +
 rtl/spi_sram_arbiter_if.sv | 33 +++
 rtl/spi_sram_arbiter_rr_pick.sv | 34 +++
 rtl/spi_sram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_spi_sram_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_sram_pkg.sv
// Shared definitions for the SPI SRAM arbiter slice: SRAM address width,
// SPI SRAM opcodes and the arbiter FSM state type.
package spi_sram_pkg;

  localparam int SRAM_ADDR_W = 24;

  localparam logic [7:0] SPI_OP_READ  = 8'h03;
  localparam logic [7:0] SPI_OP_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    CMD,
    XFER,
    GAP
  } arb_state_t;

endpackage

// File: rtl/spi_sram_arbiter_if.sv
// Requester-side bus of spi_sram_arbiter.
//  master modport : requesters (drive req/req_wr/req_addr/req_len/req_wdata,
//                   receive wnext/rvalid/rdata/done/gnt)
//  slave modport  : the arbiter (opposite directions)
interface spi_sram_arbiter_if
  import spi_sram_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int LEN_W = 4
);

  logic [NREQ-1:0]             req;
  logic [NREQ-1:0]             req_wr;
  logic [NREQ*SRAM_ADDR_W-1:0] req_addr;
  logic [NREQ*LEN_W-1:0]       req_len;
  logic [NREQ*8-1:0]           req_wdata;
  logic [NREQ-1:0]             wnext;
  logic [NREQ-1:0]             rvalid;
  logic [7:0]                  rdata;
  logic [NREQ-1:0]             done;
  logic [NREQ-1:0]             gnt;

  modport master (
    output req, req_wr, req_addr, req_len, req_wdata,
    input  wnext, rvalid, rdata, done, gnt
  );

  modport slave (
    input  req, req_wr, req_addr, req_len, req_wdata,
    output wnext, rvalid, rdata, done, gnt
  );

endinterface

// File: rtl/spi_sram_arbiter_rr_pick.sv
// Combinational round-robin picker.
//  req : request vector
//  ptr : index of the highest-priority requester
//  gnt : one-hot winner (0 when no request)
module rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic found;

  // Two passes: first the requesters at or above ptr, then wrap to the bottom.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= 32'(ptr))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_sram_arbiter.sv
// Shares one spi_sram_master among NREQ byte-burst requesters.
// Round-robin, burst-locked grant; GAP idle cycles after each burst.
//  clk, rst            : clock, synchronous active-high reset
//  rq (slave modport)  : requester bus (req/wr/addr/len/wdata, wnext/rvalid/rdata/done/gnt)
//  m_start/m_wr/m_addr/m_len/m_wdata : command to the master
//  m_wnext/m_rvalid/m_rdata/m_done/m_busy : master handshake
module spi_sram_arbiter
  import spi_sram_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int LEN_W = 4,
  parameter int GAP   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_sram_arbiter_if.slave      rq,
  output logic                   m_start,
  output logic                   m_wr,
  output logic [SRAM_ADDR_W-1:0] m_addr,
  output logic [LEN_W-1:0]       m_len,
  output logic [7:0]             m_wdata,
  input  logic                   m_wnext,
  input  logic                   m_rvalid,
  input  logic [7:0]             m_rdata,
  input  logic                   m_done,
  input  logic                   m_busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GAP_W = 2;

  arb_state_t             state_q, state_d;
  logic [NREQ-1:0]        gnt_q, gnt_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       own_q, own_d;
  logic                   wr_q, wr_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [LEN_W:0]         beat_q, beat_d;

  logic [NREQ-1:0]        pick;
  logic [PTR_W-1:0]       pick_idx;
  logic                   xfer;

  rr_pick #(.N(NREQ), .PTR_W(PTR_W)) u_rr_pick (
    .req (rq.req),
    .ptr (ptr_q),
    .gnt (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    gap_d   = gap_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: if (|rq.req && !m_busy) state_d = ARB;
      ARB: begin
        // A request withdrawn between IDLE and ARB leaves nothing to grant.
        if (|pick) begin
          gnt_d   = pick;
          own_d   = pick_idx;
          state_d = CMD;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
              wr_d   = rq.req_wr[i];
              addr_d = rq.req_addr[i*SRAM_ADDR_W +: SRAM_ADDR_W];
              len_d  = rq.req_len[i*LEN_W +: LEN_W];
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      CMD: begin
        beat_d  = '0;
        state_d = XFER;
      end
      XFER: begin
        if (m_wnext || m_rvalid) beat_d = beat_q + 1'b1;
        if (m_done) begin
          gnt_d = '0;
          ptr_d = (own_q == PTR_W'(NREQ - 1)) ? '0 : own_q + 1'b1;
          if (GAP == 0) begin
            state_d = IDLE;
          end else begin
            gap_d   = GAP_W'((GAP > 0) ? GAP - 1 : 0);
            state_d = spi_sram_pkg::GAP;
          end
        end
      end
      spi_sram_pkg::GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      own_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      beat_q  <= beat_d;
    end
  end

  assign xfer = (state_q == XFER);

  always_comb begin
    m_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) m_wdata = rq.req_wdata[i*8 +: 8];
    end
  end

  assign m_start   = (state_q == CMD);
  assign m_wr      = wr_q;
  assign m_addr    = addr_q;
  assign m_len     = len_q;
  assign rq.gnt    = gnt_q;
  assign rq.wnext  = (xfer && m_wnext)  ? gnt_q : '0;
  assign rq.rvalid = (xfer && m_rvalid) ? gnt_q : '0;
  assign rq.done   = (xfer && m_done)   ? gnt_q : '0;
  assign rq.rdata  = xfer ? m_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(m_done && !xfer))
        else $error("spi_sram_arbiter: m_done outside XFER");
      if (xfer && m_done) begin
        assert ((beat_q + (LEN_W+1)'(m_wnext | m_rvalid)) == ({1'b0, len_q} + 1'b1))
          else $error("spi_sram_arbiter: byte count differs from len+1");
      end
    end
  end

endmodule

// File: tb/tb_spi_sram_arbiter.sv
// Directed self-checking bench for spi_sram_arbiter (NREQ=3, LEN_W=4, GAP=2)
// with a behavioural SPI SRAM master and a 64 KiB memory.
module tb_spi_sram_arbiter;
  import spi_sram_pkg::*;

  localparam int NREQ  = 3;
  localparam int LEN_W = 4;
  localparam int GAP_C = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_sram_arbiter_if #(.NREQ(NREQ), .LEN_W(LEN_W)) rq_if ();

  logic        m_start, m_wr;
  logic [23:0] m_addr;
  logic [3:0]  m_len;
  logic [7:0]  m_wdata;
  logic        m_wnext, m_rvalid, m_done, m_busy;
  logic [7:0]  m_rdata;
  logic        mdl_busy;
  logic        ext_busy = 1'b0;
  assign m_busy = mdl_busy | ext_busy;

  spi_sram_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W), .GAP(GAP_C)) dut (
    .clk      (clk),
    .rst      (rst),
    .rq       (rq_if.slave),
    .m_start  (m_start),
    .m_wr     (m_wr),
    .m_addr   (m_addr),
    .m_len    (m_len),
    .m_wdata  (m_wdata),
    .m_wnext  (m_wnext),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .m_done   (m_done),
    .m_busy   (m_busy)
  );

  // ---------------- behavioural master + memory ----------------
  logic [7:0]  mem [0:65535];
  logic        mwr, msent;
  logic [23:0] maddr;
  logic [3:0]  mlen;
  logic [4:0]  mcnt, wcnt;
  logic        mtmr;

  always @(posedge clk) begin
    if (rst) begin
      mdl_busy <= 1'b0; m_wnext <= 1'b0; m_rvalid <= 1'b0; m_done <= 1'b0;
      m_rdata <= '0; mcnt <= '0; wcnt <= '0; mtmr <= 1'b0; msent <= 1'b0;
    end else begin
      m_wnext <= 1'b0; m_rvalid <= 1'b0; m_done <= 1'b0;
      if (m_wnext) begin
        mem[16'(maddr + 24'(wcnt))] = m_wdata;
        wcnt <= wcnt + 1'b1;
      end
      if (!mdl_busy) begin
        if (m_start) begin
          mdl_busy <= 1'b1; mwr <= m_wr; maddr <= m_addr; mlen <= m_len;
          mcnt <= '0; wcnt <= '0; mtmr <= 1'b1; msent <= 1'b0;
        end
      end else if (mcnt <= {1'b0, mlen}) begin
        if (!mtmr) begin
          if (mwr) m_wnext <= 1'b1;
          else begin
            m_rvalid <= 1'b1;
            m_rdata  <= mem[16'(maddr + 24'(mcnt))];
          end
          mcnt <= mcnt + 1'b1;
          mtmr <= 1'b1;
        end else begin
          mtmr <= 1'b0;
        end
      end else if (!msent) begin
        m_done <= 1'b1; msent <= 1'b1;
      end else begin
        mdl_busy <= 1'b0;
      end
    end
  end

  // ---------------- requester write data ----------------
  logic [7:0] wbuf [NREQ][16];
  logic [3:0] wpos [NREQ];

  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst || rq_if.done[i]) wpos[i] <= '0;
      else if (rq_if.wnext[i])  wpos[i] <= wpos[i] + 1'b1;
    end
  end

  always_comb begin
    rq_if.req_wdata = '0;
    for (int i = 0; i < NREQ; i++) rq_if.req_wdata[i*8 +: 8] = wbuf[i][wpos[i]];
  end

  // ---------------- monitors ----------------
  int         cyc = 0;
  logic [7:0] rdq [NREQ][$];
  int         glog [$];
  int         stq [$];
  int         dnq [$];
  int         done_cnt [NREQ] = '{default: 0};
  int         twohot = 0;
  int         busy_viol = 0;
  int         gi;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rq_if.rvalid[i]) rdq[i].push_back(rq_if.rdata);
        if (rq_if.done[i])   done_cnt[i]++;
      end
      if (m_start) begin
        gi = -1;
        for (int i = 0; i < NREQ; i++) if (rq_if.gnt[i]) gi = i;
        glog.push_back(gi);
        stq.push_back(cyc);
        if (m_busy) busy_viol++;
      end
      if (m_done) dnq.push_back(cyc);
      if ($countones(rq_if.gnt) > 1) twohot++;
    end
  end

  // ---------------- checking helpers ----------------
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input int i, input logic wr, input logic [23:0] a, input logic [3:0] l);
    rq_if.req_wr[i]          = wr;
    rq_if.req_addr[i*24 +: 24] = a;
    rq_if.req_len[i*4 +: 4]  = l;
  endtask

  task automatic wait_start(input string tag, input int bound, output int c);
    c = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (m_start) begin c = cyc; break; end
    end
    if (c < 0) chk({tag, "_start_timeout"}, 0, 1);
  endtask

  // Waits for done[i]; drops req[i] in the done cycle.
  task automatic wait_done(input string tag, input int i, input int bound);
    bit seen = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (rq_if.done[i]) begin seen = 1; break; end
    end
    rq_if.req[i] = 1'b0;
    if (!seen) chk({tag, "_done_timeout"}, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  int c0, c, base, sb, db, dsnap, gsnap, cnt;
  int exp_g [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
  logic [7:0] wdat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a) + 8'h30;
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 16; j++) wbuf[i][j] = 8'hE0 + 8'(j);
    for (int j = 0; j < 4; j++) wbuf[1][j] = wdat[j];
    rq_if.req = '0; rq_if.req_wr = '0; rq_if.req_addr = '0; rq_if.req_len = '0;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(rq_if.gnt), 0);
    chk("rst_start", 32'(m_start), 0);
    chk("rst_done", 32'(rq_if.done), 0);
    chk("rst_addr", 32'(m_addr), 0);
    chk("rst_rdata", 32'(rq_if.rdata), 0);
    rst = 1'b0;
    @(negedge clk);

    // single 16-byte read by req0
    base = rdq[0].size();
    setup(0, 1'b0, 24'h000400, 4'd15);
    c0 = cyc;
    rq_if.req[0] = 1'b1;
    wait_start("rd1", 10, c);
    chk("rd1_latency", 32'(c - c0), 2);
    chk("rd1_gnt", 32'(rq_if.gnt), 32'b001);
    chk("rd1_addr", 32'(m_addr), 32'h000400);
    chk("rd1_len", 32'(m_len), 15);
    chk("rd1_wr", 32'(m_wr), 0);
    wait_done("rd1", 0, 200);
    repeat (2) @(negedge clk);
    chk("rd1_nbytes", 32'(rdq[0].size() - base), 16);
    for (int i = 0; i < 16; i++)
      if (base + i < rdq[0].size())
        chk($sformatf("rd1_byte%0d", i), 32'(rdq[0][base+i]), 32'(8'h30 + 8'(i)));
    chk("rd1_done_cnt", 32'(done_cnt[0]), 1);
    repeat (4) @(negedge clk);

    // 4-byte write by req1; request fields changed after grant must not matter
    setup(1, 1'b1, 24'h000200, 4'd3);
    rq_if.req[1] = 1'b1;
    wait_start("wr", 10, c);
    chk("wr_gnt", 32'(rq_if.gnt), 32'b010);
    chk("wr_wr", 32'(m_wr), 1);
    setup(1, 1'b0, 24'h00ABCD, 4'hF);
    @(negedge clk);
    chk("wr_addr_latched", 32'(m_addr), 32'h000200);
    chk("wr_len_latched", 32'(m_len), 3);
    wait_done("wr", 1, 200);
    repeat (3) @(negedge clk);
    for (int j = 0; j < 4; j++)
      chk($sformatf("wr_mem%0d", j), 32'(mem[16'h0200 + 16'(j)]), 32'(wdat[j]));
    chk("wr_mem_beyond", 32'(mem[16'h0204]), 32'h34);

    // read-back by req0 (pointer now at 2, wraps to 0)
    base = rdq[0].size();
    setup(0, 1'b0, 24'h000200, 4'd3);
    rq_if.req[0] = 1'b1;
    wait_start("rb", 10, c);
    chk("rb_gnt", 32'(rq_if.gnt), 32'b001);
    wait_done("rb", 0, 200);
    repeat (2) @(negedge clk);
    chk("rb_nbytes", 32'(rdq[0].size() - base), 4);
    for (int j = 0; j < 4; j++)
      if (base + j < rdq[0].size())
        chk($sformatf("rb_byte%0d", j), 32'(rdq[0][base+j]), 32'(wdat[j]));
    repeat (4) @(negedge clk);

    // m_busy held by an external owner: no grant until it drops
    gsnap = glog.size();
    ext_busy = 1'b1;
    setup(0, 1'b0, 24'h000010, 4'd0);
    rq_if.req[0] = 1'b1;
    repeat (8) @(negedge clk);
    chk("busy_no_start", 32'(glog.size() - gsnap), 0);
    chk("busy_no_gnt", 32'(rq_if.gnt), 0);
    c0 = cyc;
    ext_busy = 1'b0;
    wait_start("busy", 10, c);
    chk("busy_release_latency", 32'(c - c0), 2);
    wait_done("busy", 0, 100);
    repeat (4) @(negedge clk);

    // contention: req0 and req1 held for 8 bursts (pointer starts at 1)
    base = glog.size(); sb = stq.size(); db = dnq.size();
    setup(0, 1'b0, 24'h000020, 4'd1);
    setup(1, 1'b0, 24'h000030, 4'd1);
    rq_if.req[0] = 1'b1; rq_if.req[1] = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (glog.size() - base >= 8) break;
    end
    rq_if.req[0] = 1'b0; rq_if.req[1] = 1'b0;
    chk("cont_nbursts", 32'(glog.size() - base), 8);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dnq.size() - db >= 8) break;
    end
    chk("cont_ndone", 32'(dnq.size() - db), 8);
    for (int k = 0; k < 8; k++)
      if (base + k < glog.size())
        chk($sformatf("cont_gnt%0d", k), 32'(glog[base+k]), 32'(exp_g[k]));
    for (int k = 0; k < 7; k++)
      if (sb + k + 1 < stq.size() && db + k < dnq.size())
        chk($sformatf("cont_gap%0d", k), 32'(stq[sb+k+1] - dnq[db+k]), 5);
    chk("cont_twohot", 32'(twohot), 0);
    chk("cont_start_while_busy", 32'(busy_viol), 0);
    repeat (6) @(negedge clk);

    // reset at the 5th byte of a 16-byte read
    setup(0, 1'b0, 24'h000400, 4'd15);
    rq_if.req[0] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rq_if.rvalid[0]) cnt++;
      if (cnt == 5) break;
    end
    chk("rstm_reached_byte5", 32'(cnt), 5);
    dsnap = done_cnt[0];
    rst = 1'b1;
    @(negedge clk);
    chk("rstm_gnt", 32'(rq_if.gnt), 0);
    chk("rstm_start", 32'(m_start), 0);
    chk("rstm_done", 32'(rq_if.done), 0);
    chk("rstm_rvalid", 32'(rq_if.rvalid), 0);
    chk("rstm_wnext", 32'(rq_if.wnext), 0);
    chk("rstm_rdata", 32'(rq_if.rdata), 0);
    chk("rstm_addr", 32'(m_addr), 0);
    chk("rstm_len", 32'(m_len), 0);
    chk("rstm_wdata", 32'(m_wdata), 0);
    rq_if.req[0] = 1'b0;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rstm_no_done", 32'(done_cnt[0] - dsnap), 0);
    base = rdq[0].size();
    setup(0, 1'b0, 24'h000408, 4'd3);
    rq_if.req[0] = 1'b1;
    wait_start("rstm_after", 10, c);
    chk("rstm_after_gnt", 32'(rq_if.gnt), 32'b001);
    wait_done("rstm_after", 0, 200);
    repeat (2) @(negedge clk);
    chk("rstm_after_nbytes", 32'(rdq[0].size() - base), 4);
    for (int j = 0; j < 4; j++)
      if (base + j < rdq[0].size())
        chk($sformatf("rstm_after_byte%0d", j), 32'(rdq[0][base+j]), 32'(8'h38 + 8'(j)));
    repeat (4) @(negedge clk);

    // lone requester 2 held high: back-to-back 1-byte bursts
    base = glog.size(); dsnap = done_cnt[2]; sb = rdq[2].size();
    setup(2, 1'b0, 24'h000010, 4'd0);
    rq_if.req[2] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (rq_if.done[2]) cnt++;
      if (cnt == 3) break;
    end
    rq_if.req[2] = 1'b0;
    repeat (30) @(negedge clk);
    chk("lone_done_cnt", 32'(done_cnt[2] - dsnap), 3);
    chk("lone_nbursts", 32'(glog.size() - base), 3);
    for (int k = 0; k < 3; k++)
      if (base + k < glog.size()) chk($sformatf("lone_gnt%0d", k), 32'(glog[base+k]), 2);
    chk("lone_nbytes", 32'(rdq[2].size() - sb), 3);
    for (int k = 0; k < 3; k++)
      if (sb + k < rdq[2].size()) chk($sformatf("lone_byte%0d", k), 32'(rdq[2][sb+k]), 32'h40);
    chk("final_twohot", 32'(twohot), 0);
    chk("final_start_while_busy", 32'(busy_viol), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
